// File: rtl/seg_pkg.sv
// ----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the 7-segment scan controller.
//   seg_state_t  : scan FSM state (IDLE / BLANK / SHOW)
//   BCD_MAX      : largest displayable BCD code
//   is_valid_bcd : true when a nibble is a displayable decimal digit
// ----------------------------------------------------------------------------
package seg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } seg_state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;

   function automatic logic is_valid_bcd(input logic [3:0] d);
      return (d <= BCD_MAX);
   endfunction

endpackage

// File: rtl/seg_dwell_timer.sv
// ----------------------------------------------------------------------------
// seg_dwell_timer
// Loadable down-counter that times the BLANK (guard) and SHOW (dwell) slots.
// Loading value L makes done assert in the L-th cycle after the load edge.
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset (counter -> 0)
//   load      in   load load_val on this edge (has priority over clr)
//   clr       in   clear the counter to 0 on this edge
//   load_val  in   CNT_W-bit slot length (GUARD or DWELL)
//   done      out  current cycle is the last cycle of the slot
//   done_nxt  out  the coming cycle will be the last cycle of the slot
// ----------------------------------------------------------------------------
module seg_dwell_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             clr,
   input  logic [CNT_W-1:0] load_val,
   output logic             done,
   output logic             done_nxt
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign done = (cnt_q == CNT_W'(1));

   // Look-ahead of done, so registered outputs can flag the last slot cycle
   // in that very cycle.
   assign done_nxt = load ? (load_val == CNT_W'(1))
                          : (!clr && (cnt_q == CNT_W'(2)));

endmodule

// File: rtl/seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scan controller for an N-digit 7-segment display sharing
// a single BCD-to-7-segment decoder. Each digit slot is GUARD dark cycles
// (decoder input pre-driven) followed by DWELL lit cycles. The digit word
// is snapshotted once per frame so a frame is never torn.
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   scan enable
//   digits_in  in   packed BCD digits, digit 0 in the top nibble
//   lz_blank   in   blank digit 0 when it is zero
//   bcd_out    out  BCD code for the shared decoder (registered)
//   digit_en   out  one-hot active-high digit enable (registered)
//   frame_done out  one-cycle pulse in the last SHOW cycle of a frame
// ----------------------------------------------------------------------------
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter int DWELL      = 1000,
   parameter int GUARD      = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic                    lz_blank,
   output logic [3:0]              bcd_out,
   output logic [NUM_DIGITS-1:0]   digit_en,
   output logic                    frame_done
);

   localparam int MAXLEN    = (DWELL > GUARD) ? DWELL : GUARD;
   localparam int CNT_W_RAW = $clog2(MAXLEN + 1);
   localparam int CNT_W     = (CNT_W_RAW < 2) ? 2 : CNT_W_RAW;
   localparam int IDX_W     = $clog2(NUM_DIGITS);
   localparam int DW        = 4 * NUM_DIGITS;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CNT_W-1:0] GUARD_C  = CNT_W'(GUARD);
   localparam logic [CNT_W-1:0] DWELL_C  = CNT_W'(DWELL);

   seg_state_t       state_q, state_n;
   logic [IDX_W-1:0] idx_q, idx_n;
   logic [DW-1:0]    snap_q, snap_n;
   logic             lz_q, lz_n;

   logic             tmr_load, tmr_clr, tmr_done, tmr_done_nxt;
   logic [CNT_W-1:0] tmr_load_val;

   logic [3:0]            nib_n, bcd_n;
   logic                  lit_n;
   logic [NUM_DIGITS-1:0] digit_en_n;
   logic                  frame_done_n;

   // Digit k sits in nibble (NUM_DIGITS-1-k), i.e. digit 0 is the top nibble.
   function automatic logic [3:0] nibble_at(input logic [DW-1:0]    s,
                                            input logic [IDX_W-1:0] i);
      logic [3:0] r;
      r = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (i == IDX_W'(k)) r = s[4*(NUM_DIGITS-1-k) +: 4];
      end
      return r;
   endfunction

   seg_dwell_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .clr      (tmr_clr),
      .load_val (tmr_load_val),
      .done     (tmr_done),
      .done_nxt (tmr_done_nxt)
   );

   // Next-state logic; the timer is (re)loaded on every BLANK/SHOW entry.
   always_comb begin
      state_n      = state_q;
      idx_n        = idx_q;
      snap_n       = snap_q;
      lz_n         = lz_q;
      tmr_load     = 1'b0;
      tmr_clr      = 1'b0;
      tmr_load_val = GUARD_C;
      case (state_q)
         IDLE: begin
            if (en) begin
               state_n  = BLANK;
               idx_n    = '0;
               snap_n   = digits_in;
               lz_n     = lz_blank;
               tmr_load = 1'b1;
            end
         end
         BLANK: begin
            if (!en) begin
               state_n = IDLE;
               idx_n   = '0;
               tmr_clr = 1'b1;
            end else if (tmr_done) begin
               state_n      = SHOW;
               tmr_load     = 1'b1;
               tmr_load_val = DWELL_C;
            end
         end
         SHOW: begin
            if (!en) begin
               state_n = IDLE;
               idx_n   = '0;
               tmr_clr = 1'b1;
            end else if (tmr_done) begin
               state_n  = BLANK;
               tmr_load = 1'b1;
               if (idx_q == LAST_IDX) begin
                  idx_n  = '0;
                  snap_n = digits_in;
                  lz_n   = lz_blank;
               end else begin
                  idx_n = idx_q + 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
            idx_n   = '0;
            tmr_clr = 1'b1;
         end
      endcase
   end

   // Outputs are derived from the next state so they can be registered
   // without adding a cycle of latency. bcd_out only changes on BLANK or
   // IDLE entry, where digit_en is always 0.
   always_comb begin
      nib_n = nibble_at(snap_n, idx_n);
      lit_n = is_valid_bcd(nib_n) &&
              !(lz_n && (idx_n == '0) && (nib_n == 4'd0));
      bcd_n = (state_n == IDLE) ? 4'd0 : nib_n;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         digit_en_n[k] = (state_n == SHOW) && lit_n && (idx_n == IDX_W'(k));
      end
   end

   assign frame_done_n = (state_n == SHOW) && (idx_n == LAST_IDX) && tmr_done_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         snap_q     <= '0;
         lz_q       <= 1'b0;
         bcd_out    <= 4'd0;
         digit_en   <= '0;
         frame_done <= 1'b0;
      end else begin
         state_q    <= state_n;
         idx_q      <= idx_n;
         snap_q     <= snap_n;
         lz_q       <= lz_n;
         bcd_out    <= bcd_n;
         digit_en   <= digit_en_n;
         frame_done <= frame_done_n;
      end
   end

endmodule
